// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_IDX_W      = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1, pulses bit_done at terminal count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == TERM)) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_done = (cnt_q == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with valid/ready byte intake; tx is registered for a glitch-free pin.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 128,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(DATA_BITS - 1);

  uart_tx_state_t                  state_q, state_d;
  logic [UART_DATA_BITS-1:0]       shift_q, shift_d;
  logic [UART_IDX_W-1:0]           idx_q, idx_d;
  logic                            tx_q, tx_d;
  logic                            handshake;
  logic                            bit_done;

  assign handshake = tx_valid && (state_q == IDLE);

  // Counter restarts on the accepting edge so the start bit is exactly one period.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (handshake),
    .bit_done(bit_done)
  );

  // tx_d is the value the line takes in the state being entered, so tx lines up with state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            idx_d   = idx_q + UART_IDX_W'(1);
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = !tx_ready;
  assign tx       = tx_q;

endmodule
